// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, port indices and default bus widths.
package mips_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int PORT_CPU   = 0;
    localparam int PORT_DMA   = 1;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker: one-hot winner from requests.
// ptr is the last winner; fixed forces ties to port 0.
module mem_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       fixed,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = (fixed || ptr) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port data memory, with locked bursts.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin ties by port-0 priority.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [3:0] MAX_B    = 4'(MAX_BURST);
    localparam bit         BURST_EN = (MAX_BURST > 1);

    arb_state_t state;
    logic       owner;
    logic [3:0] cnt;
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] win;
    logic [1:0] gnt;
    logic       ptr;
    logic       fixed;

    assign req[PORT_CPU]  = req0;
    assign req[PORT_DMA]  = req1;
    assign lock[PORT_CPU] = lock0;
    assign lock[PORT_DMA] = lock1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign fixed = 1'b1;
    assign ptr   = 1'b1;
`else
    logic ptr_q;
    assign fixed = 1'b0;
    assign ptr   = ptr_q;
`endif

    mem_arb_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .fixed (fixed),
        .win   (win)
    );

    // Grant is forced low while reset is held, even mid-burst.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (state == LOCKED) begin
                gnt[owner] = req[owner];
            end else begin
                gnt = win;
            end
        end
    end

    assign gnt0 = gnt[PORT_CPU];
    assign gnt1 = gnt[PORT_DMA];

    always_comb begin
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        if (gnt0) begin
            mem_write_enable = we0;
            mem_addr         = addr0;
            mem_write_data   = wdata0;
        end else if (gnt1) begin
            mem_write_enable = we1;
            mem_addr         = addr1;
            mem_write_data   = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_read_data;
            if (gnt1 && !we1) rdata1 <= mem_read_data;
            unique case (state)
                IDLE: begin
                    if (|win) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr_q <= win[PORT_DMA];
`endif
                        if (BURST_EN && lock[win[PORT_DMA]]) begin
                            state <= LOCKED;
                            owner <= win[PORT_DMA];
                            cnt   <= 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Leaving a burst hands tie priority to the other port.
                    if (req[owner] && lock[owner] && (cnt + 4'd1) != MAX_B) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr_q <= owner;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 1024×32 data memory between the CPU load/store port (port 0) and the DMA/debug loader port (port 1). It sits between the requesters and the `memory` block. It grants one access per cycle, supports bounded locked bursts, and returns registered read data with a one-cycle valid pulse.

## Interface
- `ADDR_W`, 10: word-address width; must match the memory.
- `DATA_W`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive locked beats per ownership; legal range 1–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0` / `req1`  in  1  access request, per port.
- `lock0` / `lock1`  in  1  request to keep ownership for following beats.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  combinational grant; the beat transfers at the rising edge where `reqN & gntN`.
- `rvalid0` / `rvalid1`  out  1  registered; high for one cycle after a granted read.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; holds its value until the next read on that port.
- `mem_write_enable`  out  1  to memory.
- `mem_addr`  out  ADDR_W  to memory.
- `mem_write_data`  out  DATA_W  to memory.
- `mem_read_data`  in  DATA_W  from memory; combinational read.

## Operation
- FSM states:
  - IDLE: no owner.
  - LOCKED: owner register plus beat counter.
- IDLE arbitration:
  - If one port requests, that port is granted.
  - If both request, round-robin picks the port that did not win last. The last-winner pointer is port 1 after reset, so port 0 wins the first tie.
- IDLE → LOCKED when the winning port has `lock` high and `MAX_BURST > 1`. The counter is set to 1 and the owner is recorded.
- In LOCKED, only the owner can be granted. The other port's `gnt` stays 0 even if it requests.
- Owner behaviour in LOCKED:
  - `req & lock`: granted; counter increments. When the counter reaches `MAX_BURST`, the block returns to IDLE and the pointer moves to the other port.
  - `req & !lock`: granted as the final beat; next state IDLE; pointer moves to the other port.
  - `!req`: no grant this cycle (one bubble); next state IDLE; pointer moves to the other port.
- Memory drive:
  - When a port is granted: `mem_addr`, `mem_write_data` and `mem_write_enable = weN` come from that port.
  - When no port is granted: all three are 0.
- Granted read: at the transfer edge `rdataN <= mem_read_data` and `rvalidN <= 1`. Otherwise `rvalidN <= 0`.
- Granted write: it commits in the memory at the transfer edge. `rvalid` stays low.

## Timing
- Reset values: `gnt0` = `gnt1` = 0 (forced while `rst_n` is low), `rvalid0` = `rvalid1` = 0, `rdata0` = `rdata1` = 0, all `mem_*` outputs 0. Internally: state IDLE, counter 0, pointer = port 1.
- Grant latency: 0 cycles (combinational from `req` and state).
- Read-data latency: `rvalid` and `rdata` are valid 1 cycle after the transfer edge.
- Handshake: a requester holds `req`, `we`, `addr`, `wdata` and `lock` stable until it samples `gnt` high at a rising edge.
- Back-to-back accesses: a port can be granted every cycle. With both ports requesting continuously in IDLE, grants alternate.
- Write then read of the same address in consecutive beats returns the new value.
- Reset asserted mid-burst: outputs clear immediately (asynchronously). After release the block is in IDLE with the port-0 tie-break.
- `MAX_BURST = 1`: `lock` is ignored and LOCKED is never entered.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: IDLE ties always go to port 0, and the round-robin pointer is not implemented. Burst limits and lock release still apply.
- `MEM_ARB_FIXED_PRIO_EN` undefined: round-robin as described above.

## Structure
- Shared package `mips_mem_pkg`:
  - FSM state encoding (IDLE = 0, LOCKED = 1).
  - Port index constants `PORT_CPU = 0`, `PORT_DMA = 1`.
  - Default `ADDR_W` and `DATA_W`.
- Sub-module `mem_arb_pick`: combinational 2-way picker. Inputs: requests, pointer, fixed-priority select. Output: one-hot winner. The top level holds the FSM, counter and response registers.

## Test plan
1. Reset, then `req0` write 0xAAAAAAAA to address 10 → `gnt0` = 1 in the same cycle, memory address 10 updated. Next, `req0` read of address 10 → `rvalid0` pulses 1 cycle later with `rdata0` = 0xAAAAAAAA.
2. `req0` and `req1` both high for 4 cycles (reads of address 10 and address 500) → grants go 0, 1, 0, 1, and each `rvalid` pulse carries the correct port's data. With `MEM_ARB_FIXED_PRIO_EN` defined → port 0 gets all 4.
3. Port 1 `lock` burst: 6 writes to addresses 20–25 with `MAX_BURST` = 4, port 0 requesting throughout → port 1 is granted 4 beats, port 0 the next beat, then port 1 resumes.
4. Port 0 locked burst with `req0` dropped after beat 2 → a bubble cycle with no grant, then `gnt1` is granted if port 1 requests.
5. Write 15 to address 20, then read address 20 in the next beat → `rdata` = 15. Write 7 and read in consecutive beats → `rdata` = 7.
6. Assert `rst_n` low during beat 2 of a locked burst → `gnt`, `rvalid` and `mem_write_enable` drop immediately. After release, a tie goes to port 0.
